merge8_rr: RTL and testbench

Round-robin merge stage: collects tuples from 8 partition streams onto one output stream, with a registered output and full valid/ready backpressure. It is the fan-in counterpart of the hash-bit distribution tree: results leaving the 8 partition lanes of the join are merged here for the single result writer. Per-lane last-tuple markers are combined into one end-of-batch marker.

---
 rtl/merge8_rr.sv | 104 ++++++++++
 tb/tb_merge8_rr.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/merge8_rr.sv
// merge8_rr: round-robin fan-in of 8 partition lanes onto one registered
// output stream with valid/ready backpressure. Per-lane last markers are
// collected and collapse into a single end-of-batch marker.
module merge8_rr #(
    parameter int INPUT_SIZE = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic [7:0]                  in_ready,
    input  logic [7:0][INPUT_SIZE-1:0]  in_data,
    input  logic [7:0][31:0]            in_tag,
    input  logic [7:0]                  in_valid,
    input  logic [7:0]                  in_last_processed,
    input  logic [7:0][63:0]            in_serialnum,
    input  logic [7:0]                  in_was_joined,
    input  logic                        out_ready,
    output logic [INPUT_SIZE-1:0]       out_data,
    output logic [31:0]                 out_tag,
    output logic                        out_valid,
    output logic                        out_last_processed,
    output logic [63:0]                 out_serialnum,
    output logic                        out_was_joined,
    output logic [2:0]                  out_src,
    output logic [31:0]                 out_count
);

    logic [2:0] rr_ptr;
    logic [7:0] done;
    logic [7:0] elig;
    logic [7:0] grant;
    logic [2:0] gidx;
    logic       found;
    logic       load;
    logic       xfer;
    logic [7:0] done_next;

    // A lane that already delivered its last tuple sits out until the batch ends.
    assign elig = in_valid & ~done;

    // Output register can take a tuple when empty or draining this cycle.
    assign load = ~out_valid | out_ready;

    // First eligible lane scanning upward from rr_ptr, wrapping modulo 8.
    always_comb begin
        found = 1'b0;
        gidx  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            logic [2:0] idx;
            idx = rr_ptr + 3'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        grant = found ? (8'b1 << gidx) : 8'b0;
    end

    // Grant is only offered when the output register can accept; held off in reset.
    assign in_ready  = reset ? 8'b0 : (grant & {8{load}});
    assign xfer      = |in_ready;
    assign done_next = done | (8'b1 << gidx);

    // Output register, arbitration pointer, batch tracking and tuple counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid          <= 1'b0;
            out_last_processed <= 1'b0;
            out_data           <= '0;
            out_tag            <= '0;
            out_serialnum      <= '0;
            out_was_joined     <= 1'b0;
            out_src            <= 3'd0;
            out_count          <= 32'd0;
            rr_ptr             <= 3'd0;
            done               <= 8'b0;
        end else if (load) begin
            if (xfer) begin
                out_valid      <= 1'b1;
                out_data       <= in_data[gidx];
                out_tag        <= in_tag[gidx];
                out_serialnum  <= in_serialnum[gidx];
                out_was_joined <= in_was_joined[gidx];
                out_src        <= gidx;
                out_count      <= out_count + 32'd1;
                rr_ptr         <= gidx + 3'd1;
                if (in_last_processed[gidx]) begin
                    // Eighth lane finishing closes the batch and clears the mask.
                    if (done_next == 8'hFF) begin
                        out_last_processed <= 1'b1;
                        done               <= 8'b0;
                    end else begin
                        out_last_processed <= 1'b0;
                        done               <= done_next;
                    end
                end else begin
                    out_last_processed <= 1'b0;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_merge8_rr.sv
// tb_merge8_rr: directed scenarios plus randomized traffic, every output
// compared each cycle against a lane-level reference model.
module tb_merge8_rr;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        in_ready;
    logic [7:0][63:0]  in_data;
    logic [7:0][31:0]  in_tag;
    logic [7:0]        in_valid;
    logic [7:0]        in_last_processed;
    logic [7:0][63:0]  in_serialnum;
    logic [7:0]        in_was_joined;
    logic              out_ready;
    logic [63:0]       out_data;
    logic [31:0]       out_tag;
    logic              out_valid;
    logic              out_last_processed;
    logic [63:0]       out_serialnum;
    logic              out_was_joined;
    logic [2:0]        out_src;
    logic [31:0]       out_count;

    merge8_rr #(.INPUT_SIZE(64)) dut (
        .clk(clk), .reset(reset), .in_ready(in_ready), .in_data(in_data),
        .in_tag(in_tag), .in_valid(in_valid), .in_last_processed(in_last_processed),
        .in_serialnum(in_serialnum), .in_was_joined(in_was_joined),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_valid(out_valid), .out_last_processed(out_last_processed),
        .out_serialnum(out_serialnum), .out_was_joined(out_was_joined),
        .out_src(out_src), .out_count(out_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Lane-side held tuples (each stays stable until transferred).
    bit [7:0]    lv, lp, lj;
    logic [63:0] ld  [8];
    logic [31:0] lt  [8];
    logic [63:0] lsn [8];
    int          seq [8];

    // Reference model state.
    int          m_ptr;
    bit [7:0]    m_done;
    bit          m_ov, m_last, m_wj;
    logic [63:0] m_data, m_sn;
    logic [31:0] m_tag, m_count;
    int          m_src;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ptr = 0; m_done = 0; m_ov = 0; m_last = 0; m_wj = 0;
        m_data = 0; m_sn = 0; m_tag = 0; m_count = 0; m_src = 0;
    endtask

    function automatic int m_grant();
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (m_ptr + k) % 8;
            if (lv[i] && !m_done[i]) return i;
        end
        return -1;
    endfunction

    task automatic new_tuple(input int i, input bit last);
        lv[i]  = 1'b1;
        lp[i]  = last;
        lj[i]  = 1'($urandom_range(0, 1));
        ld[i]  = {$urandom, $urandom};
        lt[i]  = $urandom;
        lsn[i] = (64'(i) << 56) | 64'(seq[i]);
        seq[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < 8; i++) begin
            in_valid[i]          = lv[i];
            in_last_processed[i] = lp[i];
            in_was_joined[i]     = lj[i];
            in_data[i]           = ld[i];
            in_tag[i]            = lt[i];
            in_serialnum[i]      = lsn[i];
        end
    endtask

    // One clock: drive, check in_ready, advance model, check outputs.
    task automatic cycle(input bit ordy, output int xg);
        int g;
        bit ldc;
        bit [7:0] nd;
        out_ready = ordy;
        drive();
        #1;
        g   = m_grant();
        ldc = !m_ov || ordy;
        chk("in_ready", 64'(in_ready), (ldc && g >= 0) ? 64'(8'h1 << g) : 64'h0);
        xg = (ldc && g >= 0) ? g : -1;
        if (ldc) begin
            if (g >= 0) begin
                m_ov = 1; m_data = ld[g]; m_tag = lt[g]; m_sn = lsn[g]; m_wj = lj[g];
                m_src = g; m_ptr = (g + 1) % 8; m_count = m_count + 32'd1;
                nd = m_done | (8'h1 << g);
                if (lp[g]) begin
                    m_last = (nd == 8'hFF);
                    m_done = m_last ? 8'h0 : nd;
                end else begin
                    m_last = 0;
                end
            end else begin
                m_ov = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data", out_data, m_data);
        chk("out_tag", 64'(out_tag), 64'(m_tag));
        chk("out_sn", out_serialnum, m_sn);
        chk("out_wj", 64'(out_was_joined), 64'(m_wj));
        chk("out_src", 64'(out_src), 64'(m_src));
        chk("out_last", 64'(out_last_processed), 64'(m_last));
        chk("out_count", 64'(out_count), 64'(m_count));
        if (xg >= 0) lv[xg] = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rdy"}, 64'(in_ready), 64'h0);
        chk({tag, "_ov"}, 64'(out_valid), 64'h0);
        chk({tag, "_cnt"}, 64'(out_count), 64'h0);
        chk({tag, "_data"}, out_data, 64'h0);
        chk({tag, "_sn"}, out_serialnum, 64'h0);
        chk({tag, "_misc"}, 64'({out_tag, out_src, out_last_processed, out_was_joined}), 64'h0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_zero(tag);
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input int lane, input bit last, input bit exp_last);
        int xg;
        new_tuple(lane, last);
        for (int t = 0; t < 20; t++) begin
            cycle(1'b1, xg);
            if (xg >= 0) begin
                chk("send_src", 64'(xg), 64'(lane));
                chk("send_last", 64'(out_last_processed), 64'(exp_last));
                return;
            end
        end
        chk("send_timeout", 64'(lv[lane]), 64'h0);
    endtask

    initial begin
        int xg;
        int order [8] = '{3, 0, 7, 1, 2, 4, 5, 6};
        logic [63:0] sn0;
        logic [31:0] c0;

        reset = 1'b1; out_ready = 1'b1;
        lv = 0; lp = 0; lj = 0;
        for (int i = 0; i < 8; i++) begin
            seq[i] = 0; ld[i] = 0; lt[i] = 0; lsn[i] = 0;
        end
        m_reset();

        // Reset with every lane valid: nothing accepted.
        for (int i = 0; i < 8; i++) new_tuple(i, 0);
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        reset = 1'b0;

        // Round robin, 16 back-to-back transfers starting at lane 0.
        for (int k = 0; k < 16; k++) begin
            cycle(1'b1, xg);
            chk("rr_src", 64'(out_src), 64'(k % 8));
            if (xg >= 0) new_tuple(xg, 0);
        end
        chk("rr_count", 64'(out_count), 64'd16);

        // Backpressure: output frozen, nothing accepted.
        sn0 = out_serialnum;
        c0  = out_count;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, xg);
            chk("bp_hold_sn", out_serialnum, sn0);
            chk("bp_hold_cnt", 64'(out_count), 64'(c0));
        end
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, xg);
            if (xg >= 0) new_tuple(xg, 0);
        end

        // Batch end with lasts in order 3,0,7,1,2,4,5,6; next-batch lane 3 stalls.
        do_reset("rst2");
        lv = 0;
        for (int idx = 0; idx < 8; idx++) begin
            send(order[idx], 1'b1, idx == 7);
            if (idx == 0) new_tuple(3, 0);
        end
        cycle(1'b1, xg);
        chk("next3", 64'(xg), 64'd3);
        chk("next3_last", 64'(out_last_processed), 64'h0);

        // Sparse: lane 5 alone every other cycle.
        lv = 0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) new_tuple(5, 0);
            cycle(1'b1, xg);
            if (k % 2 == 0) chk("sp_src", 64'(out_src), 64'd5);
            chk("sp_valid", 64'(out_valid), 64'(k % 2 == 0));
        end

        // Mid-batch reset with four lanes done and a tuple held.
        do_reset("rst3");
        lv = 0;
        for (int i = 0; i < 4; i++) send(i, 1'b1, 1'b0);
        chk("pre_mid_ov", 64'(out_valid), 64'h1);
        reset = 1'b1;
        #1;
        check_zero("mid");
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) send((i + 4) % 8, 1'b1, i == 7);

        // Random traffic with random backpressure and sparse last markers.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 8; i++)
                if (!lv[i] && $urandom_range(0, 1) == 1)
                    new_tuple(i, $urandom_range(0, 7) == 0);
            cycle($urandom_range(0, 3) != 0, xg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
